box_tracker: RTL and testbench

BOX_TRACKER -- requirements
Module: box_tracker

---
 rtl/box_tracker_if.sv | 27 ++
 rtl/box_tracker.sv | 146 ++++++++++++++
 tb/tb_box_tracker.sv | 131 +++++++++++++
 3 files changed

// File: rtl/box_tracker_if.sv
// Bundle of frame-sync, bounding-box inputs and tracked-target outputs exchanged
// between the box stage (master) and the tracker (slave).
interface box_tracker_if;
  logic        en;
  logic        vs_n;
  logic [12:0] T;
  logic [12:0] B;
  logic [12:0] L;
  logic [12:0] R;
  logic [12:0] cx;
  logic [12:0] cy;
  logic [12:0] box_w;
  logic [12:0] box_h;
  logic        locked;
  logic        lost;
  logic        upd;

  modport master (
    output en, vs_n, T, B, L, R,
    input  cx, cy, box_w, box_h, locked, lost, upd
  );

  modport slave (
    input  en, vs_n, T, B, L, R,
    output cx, cy, box_w, box_h, locked, lost, upd
  );
endinterface

// File: rtl/box_tracker.sv
// Per-frame bounding-box tracker: validates each box, smooths its centre with a
// first-order IIR filter and tracks lock / loss of the target.
module box_tracker #(
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480,
  parameter int MIN_SIZE    = 4,
  parameter int LOST_FRAMES = 8,
  parameter int ALPHA_SHIFT = 2
) (
  input  logic         clk,
  input  logic         reset,
  box_tracker_if.slave bus
);
  localparam int DATA_W = 13;
  localparam int MISS_W = $clog2(LOST_FRAMES + 1);
  localparam logic [DATA_W-1:0] W_LIM   = DATA_W'(IMG_W);
  localparam logic [DATA_W-1:0] H_LIM   = DATA_W'(IMG_H);
  localparam logic [DATA_W-1:0] MIN_LIM = DATA_W'(MIN_SIZE);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(LOST_FRAMES);

  typedef enum logic [1:0] {IDLE, CHECK, FILTER} state_t;

  state_t              state, state_nxt;
  logic                vs_d;
  logic                frame_evt;
  logic                capture;
  logic [DATA_W-1:0]   t_p0, b_p0, l_p0, r_p0;
  logic                acc_c;
  logic [DATA_W:0]     sx_c, sy_c;
  logic [DATA_W-1:0]   w_c, h_c;
  logic                unused_lsb;
  logic                acc_p1;
  logic [DATA_W-1:0]   rx_p1, ry_p1, w_p1, h_p1;
  logic [MISS_W-1:0]   miss_cnt, miss_nxt;

  // cur + ((raw - cur) >>> ALPHA_SHIFT); the result lies between cur and raw
  function automatic logic [DATA_W-1:0] smooth(input logic [DATA_W-1:0] cur,
                                               input logic [DATA_W-1:0] raw);
    logic signed [DATA_W:0] diff;
    logic signed [DATA_W:0] step;
    logic signed [DATA_W:0] sum;
    diff = $signed({1'b0, raw}) - $signed({1'b0, cur});
    step = diff >>> ALPHA_SHIFT;
    sum  = $signed({1'b0, cur}) + step;
    return sum[DATA_W-1:0];
  endfunction

  function automatic logic [MISS_W-1:0] miss_inc(input logic [MISS_W-1:0] v);
    return (v >= MISS_MAX) ? v : v + 1'b1;
  endfunction

  assign frame_evt = vs_d & ~bus.vs_n;
  assign miss_nxt  = miss_inc(miss_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_d  <= 1'b1;
      state <= IDLE;
    end else begin
      vs_d  <= bus.vs_n;
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (frame_evt && bus.en) begin
          capture   = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK:   state_nxt = FILTER;
      FILTER:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: geometry check and raw centre; sums are one bit wider
  always_comb begin
    sx_c       = {1'b0, l_p0} + {1'b0, r_p0};
    sy_c       = {1'b0, t_p0} + {1'b0, b_p0};
    w_c        = r_p0 - l_p0 + 1'b1;
    h_c        = b_p0 - t_p0 + 1'b1;
    unused_lsb = sx_c[0] ^ sy_c[0];
    acc_c      = (t_p0 <= b_p0) && (l_p0 <= r_p0) &&
                 (b_p0 < H_LIM) && (r_p0 < W_LIM) &&
                 (h_c >= MIN_LIM) && (w_c >= MIN_LIM);
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      t_p0 <= bus.T;
      b_p0 <= bus.B;
      l_p0 <= bus.L;
      r_p0 <= bus.R;
    end
    if (state == CHECK) begin
      acc_p1 <= acc_c;
      rx_p1  <= sx_c[DATA_W:1];
      ry_p1  <= sy_c[DATA_W:1];
      w_p1   <= w_c;
      h_p1   <= h_c;
    end
  end

  // Stage p1 -> outputs: filter update, lock and loss bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.cx     <= '0;
      bus.cy     <= '0;
      bus.box_w  <= '0;
      bus.box_h  <= '0;
      bus.locked <= 1'b0;
      bus.lost   <= 1'b0;
      bus.upd    <= 1'b0;
      miss_cnt   <= '0;
    end else begin
      bus.upd <= (state == FILTER);
      if (state == FILTER) begin
        if (acc_p1) begin
          if (bus.locked) begin
            bus.cx <= smooth(bus.cx, rx_p1);
            bus.cy <= smooth(bus.cy, ry_p1);
          end else begin
            bus.cx <= rx_p1;
            bus.cy <= ry_p1;
          end
          bus.box_w  <= w_p1;
          bus.box_h  <= h_p1;
          bus.locked <= 1'b1;
          bus.lost   <= 1'b0;
          miss_cnt   <= '0;
        end else begin
          miss_cnt <= miss_nxt;
          if (miss_nxt == MISS_MAX) begin
            bus.locked <= 1'b0;
            bus.lost   <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_box_tracker.sv
// Directed bench for box_tracker: acquisition, smoothing, rejection, loss,
// boundary boxes, ignored sync pulses, enable gating and asynchronous reset.
module tb_box_tracker;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  box_tracker_if bus();

  box_tracker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [12:0] ecx, input logic [12:0] ecy,
                           input logic [12:0] ew, input logic [12:0] eh,
                           input logic elocked, input logic elost);
    check_eq({tag, ".cx"},     bus.cx,     ecx);
    check_eq({tag, ".cy"},     bus.cy,     ecy);
    check_eq({tag, ".box_w"},  bus.box_w,  ew);
    check_eq({tag, ".box_h"},  bus.box_h,  eh);
    check_eq({tag, ".locked"}, bus.locked, elocked);
    check_eq({tag, ".lost"},   bus.lost,   elost);
  endtask

  // Frame event at edge k; returns just after edge k+2 with upd expected high
  task automatic run_frame(input logic [12:0] t, input logic [12:0] b,
                           input logic [12:0] l, input logic [12:0] r);
    @(negedge clk);
    check_eq("upd_idle", bus.upd, 1'b0);
    bus.T = t; bus.B = b; bus.L = l; bus.R = r;
    bus.vs_n = 1'b0;
    @(negedge clk);
    bus.vs_n = 1'b1;
    @(negedge clk);
    check_eq("upd_k1", bus.upd, 1'b0);
    @(negedge clk);
    check_eq("upd_k2", bus.upd, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.en = 1'b1; bus.vs_n = 1'b1;
    bus.T = '0; bus.B = '0; bus.L = '0; bus.R = '0;
    repeat (2) @(negedge clk);
    check_out("reset", 0, 0, 0, 0, 1'b0, 1'b0);
    check_eq("reset.upd", bus.upd, 1'b0);
    reset = 1'b0;

    run_frame(100, 139, 200, 279); check_out("acquire",   239, 119, 80, 40, 1'b1, 1'b0);
    run_frame(100, 139, 240, 319); check_out("smooth_up", 249, 119, 80, 40, 1'b1, 1'b0);
    run_frame(100, 139, 200, 239); check_out("smooth_dn", 241, 119, 40, 40, 1'b1, 1'b0);
    run_frame(100, 139, 300, 302); check_out("reject_w3", 241, 119, 40, 40, 1'b1, 1'b0);
    run_frame(100, 139, 238, 244); check_out("small_ok",  241, 119,  7, 40, 1'b1, 1'b0);

    for (int i = 1; i <= 8; i++) begin
      run_frame(140, 100, 238, 244);
      check_out($sformatf("miss%0d", i), 241, 119, 7, 40, (i < 8), (i == 8));
    end

    run_frame(0, 479, 0, 639);   check_out("reacq_max", 319, 239, 640, 480, 1'b1, 1'b0);
    run_frame(0, 10, 600, 640);  check_out("rej_r640",  319, 239, 640, 480, 1'b1, 1'b0);
    run_frame(470, 480, 0, 10);  check_out("rej_b480",  319, 239, 640, 480, 1'b1, 1'b0);

    // Second sync pulse lands while the first frame is still being processed
    @(negedge clk);
    bus.T = 0; bus.B = 9; bus.L = 0; bus.R = 9; bus.vs_n = 1'b0;
    @(negedge clk); bus.vs_n = 1'b1;
    @(negedge clk); bus.vs_n = 1'b0;
    @(negedge clk); bus.vs_n = 1'b1;
    check_eq("glitch.upd", bus.upd, 1'b1);
    check_out("glitch", 240, 180, 10, 10, 1'b1, 1'b0);
    @(negedge clk); check_eq("glitch.upd_k3", bus.upd, 1'b0);
    @(negedge clk); check_eq("glitch.upd_k4", bus.upd, 1'b0);

    @(negedge clk);
    bus.en = 1'b0; bus.vs_n = 1'b0;
    @(negedge clk); bus.vs_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("en0.upd%0d", i), bus.upd, 1'b0);
    end
    check_out("en0", 240, 180, 10, 10, 1'b1, 1'b0);
    bus.en = 1'b1;

    // Enable drops right after capture; the in-flight frame still completes
    @(negedge clk);
    bus.T = 100; bus.B = 139; bus.L = 240; bus.R = 319; bus.vs_n = 1'b0;
    @(negedge clk); bus.vs_n = 1'b1; bus.en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("en_mid.upd", bus.upd, 1'b1);
    check_out("en_mid", 249, 164, 80, 40, 1'b1, 1'b0);
    bus.en = 1'b1;

    @(negedge clk);
    bus.T = 100; bus.B = 139; bus.L = 240; bus.R = 319; bus.vs_n = 1'b0;
    @(negedge clk); bus.vs_n = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_out("async_rst", 0, 0, 0, 0, 1'b0, 1'b0);
    check_eq("async_rst.upd", bus.upd, 1'b0);
    @(negedge clk);
    check_eq("async_rst.upd_k2", bus.upd, 1'b0);
    reset = 1'b0;

    run_frame(100, 139, 240, 319); check_out("reacq_rst", 279, 119, 80, 40, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
